reset_seq_ctrl: RTL and testbench

Parametrised reset supervisor and sequencer that generalises per-domain reset synchronisation into N ordered reset channels.
- Drives the PLL reset and monitors PLL lock through a synchroniser and a lock filter.
- Releases NUM_CH active-low channel resets in fixed order (ch0 first), spaced by a programmable delay.
- Reasserts all channels on lock loss or software request; retries PLL reset on lock timeout.
- Sits beside clk_ctrl in the clock/reset top; its outputs feed the per-domain reset_sync instances.

---
 rtl/reset_seq_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_reset_seq_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : reset_seq_ctrl
//  Purpose  : Reset supervisor/sequencer. Pulses the PLL reset, filters the
//             synchronised PLL lock, then releases NUM_CH active-low channel
//             resets in ascending order, STAGE_DLY cycles apart. Lock loss
//             or a software request pulls every channel back into reset.
//  Ports    : clk           - single clock domain
//             reset         - asynchronous active-high reset
//             pll_locked    - asynchronous PLL lock input
//             sw_rst_req    - single-cycle software reset request
//             pll_reset     - active-high PLL reset
//             rst_n_out     - active-low channel resets, bit k = channel k
//             all_ready     - high only while every channel runs
//             lock_loss_cnt - saturating count of lock-loss events
//             timeout_err   - sticky lock-timeout flag
//             state_o       - current state encoding
//  Revision : 1.0 - initial release
// ============================================================================
module reset_seq_ctrl #(
   parameter int NUM_CH        = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int LOCK_FILT     = 16,
   parameter int STAGE_DLY     = 64,
   parameter int PLL_RST_PULSE = 16,
   parameter int LOCK_TIMEOUT  = 1048576,
   parameter int CNT_W         = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pll_locked,
   input  logic              sw_rst_req,
   output logic              pll_reset,
   output logic [NUM_CH-1:0] rst_n_out,
   output logic              all_ready,
   output logic [CNT_W-1:0]  lock_loss_cnt,
   output logic              timeout_err,
   output logic [2:0]        state_o
);

   // One shared timer covers every timed state; size it for the longest.
   localparam int REL_END = NUM_CH * STAGE_DLY;
   localparam int MAX_A   = (LOCK_TIMEOUT > PLL_RST_PULSE) ? LOCK_TIMEOUT : PLL_RST_PULSE;
   localparam int MAX_B   = ((REL_END + 1) > MAX_A) ? (REL_END + 1) : MAX_A;
   localparam int TMR_W   = $clog2(MAX_B + 1);
   localparam int FLT_W   = $clog2(LOCK_FILT + 1);

   localparam logic [TMR_W-1:0] PULSE_LAST   = TMR_W'(PLL_RST_PULSE - 1);
   localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] HOLD_LAST    = TMR_W'(STAGE_DLY - 1);
   localparam logic [TMR_W-1:0] REL_LAST     = TMR_W'(REL_END);
   localparam logic [FLT_W-1:0] FILT_FULL    = FLT_W'(LOCK_FILT);

   typedef enum logic [2:0] {
      S_PLL_RST   = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_RELEASE   = 3'd2,
      S_RUN       = 3'd3,
      S_SWHOLD    = 3'd4
   } state_t;

   state_t                 state_q;
   logic [TMR_W-1:0]       tmr_q;
   logic                   pll_reset_q;
   logic [NUM_CH-1:0]      rst_n_q;
   logic                   all_ready_q;
   logic [CNT_W-1:0]       loss_cnt_q;
   logic                   timeout_err_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [FLT_W-1:0]       filt_q;

   logic                   lock_s;
   logic                   lock_f;
   logic [TMR_W-1:0]       tmr_inc;
   logic [NUM_CH-1:0]      ch_due;

   // ------------------------------------------------------------------------
   // Lock synchroniser and filter. The filter count saturates at LOCK_FILT;
   // lock_f is gated by the live synchronised bit so it drops on the very
   // first synchronised low without waiting for the counter to clear.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         filt_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
         if (!lock_s) begin
            filt_q <= '0;
         end else if (filt_q != FILT_FULL) begin
            filt_q <= filt_q + 1'b1;
         end
      end
   end

   assign lock_s  = sync_q[SYNC_STAGES-1];
   assign lock_f  = lock_s && (filt_q == FILT_FULL);
   assign tmr_inc = tmr_q + 1'b1;

   // Channel k is due once the timer (as it will read after this edge)
   // reaches (k+1)*STAGE_DLY; bits are OR-ed in so they never drop mid-release.
   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign ch_due[k] = (tmr_inc >= TMR_W'((k + 1) * STAGE_DLY));
   end

   // ------------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_PLL_RST;
         tmr_q         <= '0;
         pll_reset_q   <= 1'b1;
         rst_n_q       <= '0;
         all_ready_q   <= 1'b0;
         loss_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         case (state_q)
            S_PLL_RST: begin
               if (tmr_q == PULSE_LAST) begin
                  state_q     <= S_WAIT_LOCK;
                  tmr_q       <= '0;
                  pll_reset_q <= 1'b0;
               end else begin
                  tmr_q <= tmr_inc;
               end
            end

            S_WAIT_LOCK: begin
               // Lock is tested first so it wins on the timeout cycle.
               if (lock_f) begin
                  state_q <= S_RELEASE;
                  tmr_q   <= '0;
               end else if (tmr_q == TIMEOUT_LAST) begin
                  state_q       <= S_PLL_RST;
                  tmr_q         <= '0;
                  pll_reset_q   <= 1'b1;
                  timeout_err_q <= 1'b1;
               end else begin
                  tmr_q <= tmr_inc;
               end
            end

            S_RELEASE, S_RUN, S_SWHOLD: begin
               if (!lock_f) begin
                  // Lock loss outranks a simultaneous software request.
                  state_q     <= S_PLL_RST;
                  tmr_q       <= '0;
                  pll_reset_q <= 1'b1;
                  rst_n_q     <= '0;
                  all_ready_q <= 1'b0;
                  if (loss_cnt_q != {CNT_W{1'b1}}) begin
                     loss_cnt_q <= loss_cnt_q + 1'b1;
                  end
               end else if (sw_rst_req && (state_q != S_SWHOLD)) begin
                  state_q     <= S_SWHOLD;
                  tmr_q       <= '0;
                  rst_n_q     <= '0;
                  all_ready_q <= 1'b0;
               end else if (state_q == S_RELEASE) begin
                  rst_n_q <= rst_n_q | ch_due;
                  tmr_q   <= tmr_inc;
                  if (tmr_q == REL_LAST) begin
                     state_q     <= S_RUN;
                     all_ready_q <= 1'b1;
                  end
               end else if (state_q == S_SWHOLD) begin
                  if (tmr_q == HOLD_LAST) begin
                     state_q <= S_RELEASE;
                     tmr_q   <= '0;
                  end else begin
                     tmr_q <= tmr_inc;
                  end
               end
            end

            default: begin
               state_q     <= S_PLL_RST;
               tmr_q       <= '0;
               pll_reset_q <= 1'b1;
               rst_n_q     <= '0;
               all_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign pll_reset     = pll_reset_q;
   assign rst_n_out     = rst_n_q;
   assign all_ready     = all_ready_q;
   assign lock_loss_cnt = loss_cnt_q;
   assign timeout_err   = timeout_err_q;
   assign state_o       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reset_seq_ctrl
//  Purpose  : Self-checking bench for reset_seq_ctrl: table-driven power-up
//             vectors, directed corner sequences and randomised lock/software
//             stimulus compared every cycle against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reset_seq_ctrl;

   localparam int NCH   = 3;
   localparam int SYNC  = 2;
   localparam int FILT  = 4;
   localparam int DLY   = 4;
   localparam int PULSE = 8;
   localparam int TMO   = 100;
   localparam int CW    = 2;

   localparam int P_PLL  = 0;
   localparam int P_WAIT = 1;
   localparam int P_REL  = 2;
   localparam int P_RUN  = 3;
   localparam int P_SW   = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           pll_locked;
   logic           sw_rst_req;
   logic           pll_reset;
   logic [NCH-1:0] rst_n_out;
   logic           all_ready;
   logic [CW-1:0]  lock_loss_cnt;
   logic           timeout_err;
   logic [2:0]     state_o;

   int checks = 0;
   int errors = 0;
   int ncyc   = 0;

   reset_seq_ctrl #(
      .NUM_CH(NCH), .SYNC_STAGES(SYNC), .LOCK_FILT(FILT), .STAGE_DLY(DLY),
      .PLL_RST_PULSE(PULSE), .LOCK_TIMEOUT(TMO), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset(rst), .pll_locked(pll_locked), .sw_rst_req(sw_rst_req),
      .pll_reset(pll_reset), .rst_n_out(rst_n_out), .all_ready(all_ready),
      .lock_loss_cnt(lock_loss_cnt), .timeout_err(timeout_err), .state_o(state_o)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------- model
   // Phase plus cycles spent in it; lock is judged from the raw input
   // history: visible after an edge when the FILT+1 samples ending SYNC-1
   // edges back are all high.
   int m_phase, m_e, m_cnt;
   bit m_lf, m_terr;
   bit inq[$];

   function automatic void model_reset();
      m_phase = P_PLL; m_e = 0; m_cnt = 0; m_lf = 0; m_terr = 0;
      inq.delete();
   endfunction

   function automatic bit window_locked();
      int s = inq.size();
      if (s < SYNC + FILT) return 1'b0;
      for (int i = s - SYNC - FILT; i <= s - SYNC; i++)
         if (!inq[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic void model_step(input bit lk, input bit sw);
      int e  = m_e + 1;
      int np = m_phase;
      if (m_phase == P_PLL) begin
         if (e == PULSE) np = P_WAIT;
      end else if (m_phase == P_WAIT) begin
         if (m_lf) np = P_REL;
         else if (e == TMO) begin np = P_PLL; m_terr = 1; end
      end else begin
         if (!m_lf) begin
            np = P_PLL;
            m_cnt = (m_cnt + 1 > 3) ? 3 : m_cnt + 1;
         end else if (sw && m_phase != P_SW) np = P_SW;
         else if (m_phase == P_REL && e == NCH * DLY + 1) np = P_RUN;
         else if (m_phase == P_SW && e == DLY) np = P_REL;
      end
      m_e     = (np != m_phase) ? 0 : e;
      m_phase = np;
      inq.push_back(lk);
      if (inq.size() > 64) void'(inq.pop_front());
      m_lf = window_locked();
   endfunction

   function automatic logic [NCH-1:0] exp_rstn();
      logic [NCH-1:0] r = '0;
      if (m_phase == P_RUN) r = '1;
      else if (m_phase == P_REL)
         for (int k = 0; k < NCH; k++) r[k] = (m_e >= (k + 1) * DLY);
      return r;
   endfunction

   // ---------------------------------------------------------------- checks
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t cyc=%0d: got %0h expected %0h", nm, $time, ncyc, act, exp);
      end
   endtask

   task automatic compare_all();
      chk("m_pll_reset", 32'(pll_reset), 32'(m_phase == P_PLL));
      chk("m_rst_n_out", 32'(rst_n_out), 32'(exp_rstn()));
      chk("m_all_ready", 32'(all_ready), 32'(m_phase == P_RUN));
      chk("m_lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_cnt));
      chk("m_timeout_err", 32'(timeout_err), 32'(m_terr));
      chk("m_state", 32'(state_o), 32'(m_phase));
   endtask

   // Drive inputs for the next edge, advance the model, then sample 1 ns
   // after the edge.
   task automatic cyc(input bit lk, input bit sw);
      pll_locked = lk;
      sw_rst_req = sw;
      model_step(lk, sw);
      @(posedge clk);
      #1;
      ncyc++;
      compare_all();
   endtask

   task automatic do_reset();
      rst = 1'b1; pll_locked = 1'b0; sw_rst_req = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      ncyc = 0;
      compare_all();
   endtask

   task automatic wait_ready(input string nm);
      int k = 0;
      while (!all_ready && k < 200) begin cyc(1'b1, 1'b0); k++; end
      chk(nm, 32'(all_ready), 32'd1);
   endtask

   task automatic drop_lock();
      repeat (SYNC + 1) cyc(1'b0, 1'b0);
   endtask

   typedef struct {
      int         n;
      bit         lk;
      logic       pr;
      logic [2:0] rstn;
      logic       ar;
      logic [2:0] st;
   } vec_t;
   vec_t tv[11];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      // Power-up with lock held from cycle 0: RELEASE entered after edge 9,
      // channels after edges 13/17/21, RUN after edge 22.
      tv[0]  = '{0,  1'b1, 1'b1, 3'b000, 1'b0, 3'd0};
      tv[1]  = '{7,  1'b1, 1'b1, 3'b000, 1'b0, 3'd0};
      tv[2]  = '{8,  1'b1, 1'b0, 3'b000, 1'b0, 3'd1};
      tv[3]  = '{9,  1'b1, 1'b0, 3'b000, 1'b0, 3'd2};
      tv[4]  = '{12, 1'b1, 1'b0, 3'b000, 1'b0, 3'd2};
      tv[5]  = '{13, 1'b1, 1'b0, 3'b001, 1'b0, 3'd2};
      tv[6]  = '{16, 1'b1, 1'b0, 3'b001, 1'b0, 3'd2};
      tv[7]  = '{17, 1'b1, 1'b0, 3'b011, 1'b0, 3'd2};
      tv[8]  = '{20, 1'b1, 1'b0, 3'b011, 1'b0, 3'd2};
      tv[9]  = '{21, 1'b1, 1'b0, 3'b111, 1'b0, 3'd2};
      tv[10] = '{22, 1'b1, 1'b0, 3'b111, 1'b1, 3'd3};

      rst = 1'b1; pll_locked = 1'b0; sw_rst_req = 1'b0;
      do_reset();

      foreach (tv[i]) begin
         while (ncyc < tv[i].n) cyc(tv[i].lk, 1'b0);
         chk("vec_pll_reset", 32'(pll_reset), 32'(tv[i].pr));
         chk("vec_rst_n_out", 32'(rst_n_out), 32'(tv[i].rstn));
         chk("vec_all_ready", 32'(all_ready), 32'(tv[i].ar));
         chk("vec_state", 32'(state_o), 32'(tv[i].st));
      end
      chk("pwrup_cnt", 32'(lock_loss_cnt), 32'd0);

      // Lock loss in RUN: channels drop exactly SYNC+1 edges after the input.
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      chk("loss_not_early", 32'(rst_n_out), 32'h7);
      cyc(1'b0, 1'b0);
      chk("loss_rst_n", 32'(rst_n_out), 32'h0);
      chk("loss_cnt1", 32'(lock_loss_cnt), 32'd1);
      chk("loss_pll_reset", 32'(pll_reset), 32'd1);

      // Timeout: PULSE cycles of PLL reset then TMO cycles of waiting.
      begin
         int k = 0;
         while (!timeout_err && k < 300) begin cyc(1'b0, 1'b0); k++; end
         chk("timeout_latency", 32'(k), 32'(PULSE + TMO));
         chk("timeout_retry_pll", 32'(pll_reset), 32'd1);
         chk("timeout_state", 32'(state_o), 32'd0);
      end
      wait_ready("timeout_relock");
      chk("timeout_sticky", 32'(timeout_err), 32'd1);

      // Software reset from RUN: 4-cycle hold, re-release, no PLL reset.
      cyc(1'b1, 1'b1);
      chk("sw_rst_n", 32'(rst_n_out), 32'h0);
      chk("sw_state", 32'(state_o), 32'd4);
      repeat (3) cyc(1'b1, 1'b0);
      chk("sw_hold", 32'(state_o), 32'd4);
      cyc(1'b1, 1'b0);
      chk("sw_rerelease", 32'(state_o), 32'd2);
      repeat (13) cyc(1'b1, 1'b0);
      chk("sw_ready", 32'(all_ready), 32'd1);
      chk("sw_no_pll", 32'(pll_reset), 32'd0);
      chk("sw_cnt", 32'(lock_loss_cnt), 32'd1);

      // Software request on the same edge as lock loss: loss wins.
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b1);
      chk("both_cnt", 32'(lock_loss_cnt), 32'd2);
      chk("both_pll", 32'(pll_reset), 32'd1);

      // Three more losses: five in total saturates a 2-bit count at 3.
      repeat (3) begin
         wait_ready("sat_relock");
         drop_lock();
      end
      chk("sat_cnt", 32'(lock_loss_cnt), 32'd3);

      // Reset mid-release with ch0 already out of reset.
      begin
         int k = 0;
         while (!rst_n_out[0] && k < 200) begin cyc(1'b1, 1'b0); k++; end
         chk("mid_state", 32'(state_o), 32'd2);
         #1 rst = 1'b1;
         #1;
         chk("mid_pll_reset", 32'(pll_reset), 32'd1);
         chk("mid_rst_n", 32'(rst_n_out), 32'd0);
         chk("mid_all_ready", 32'(all_ready), 32'd0);
         chk("mid_cnt", 32'(lock_loss_cnt), 32'd0);
         chk("mid_terr", 32'(timeout_err), 32'd0);
         chk("mid_st", 32'(state_o), 32'd0);
      end

      // Lock glitch: high 3, low 1, then high; filter restarts.
      do_reset();
      while (ncyc < 10) cyc(ncyc + 1 != 4, 1'b0);
      chk("glitch_wait", 32'(state_o), 32'd1);
      cyc(1'b1, 1'b0);
      chk("glitch_release", 32'(state_o), 32'd2);
      wait_ready("glitch_ready");

      // Randomised lock drops and software requests against the model.
      begin
         bit lk = 1'b1;
         for (int i = 0; i < 3000; i++) begin
            if (lk ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 24) == 0)) lk = ~lk;
            cyc(lk, $urandom_range(0, 29) == 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
